pc_sequencer: RTL

Instruction-cycle controller for the register file's program counter. It sequences each instruction through fetch, decode, execute and PC-update phases, and owns the `load_pc`/`sel_pc` controls of the register file. It also generates the phase enables for the instruction register and the datapath. It sits between the top-level start/halt controls, the instruction memory and the datapath, and keeps a retired-instruction count for the test harness.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/pc_sequencer_wait_counter.sv | 28 ++
 rtl/pc_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and register-file PC source select codes.
package cpu_pkg;

    // Sequencer states. The encoding is visible on state_o for debug.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD_START = 3'd1,
        FETCH      = 3'd2,
        DECODE     = 3'd3,
        EXECUTE    = 3'd4,
        PC_UPDATE  = 3'd5,
        HALTED     = 3'd6
    } pc_state_t;

    // PC source select. The register file decodes these same values.
    typedef logic [1:0] pc_sel_t;
    localparam pc_sel_t PC_SEL_INC   = 2'b00;
    localparam pc_sel_t PC_SEL_START = 2'b01;
    localparam pc_sel_t PC_SEL_DP    = 2'b11;

    // Width of the fetch wait counter.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/pc_sequencer_wait_counter.sv
// Loadable down-counter; o_done is high while the count is zero.
module wait_counter #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Load takes priority; decrement saturates at zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Instruction-cycle controller: steps each instruction through fetch, decode,
// execute and PC update, drives the register-file PC controls and phase
// enables, and counts retired instructions.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int FETCH_WAIT = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             exec_busy,
    input  logic             branch_taken,
    output logic             load_pc,
    output logic [1:0]       sel_pc,
    output logic             en_ir,
    output logic             en_exec,
    output logic             running,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    // Counter preload so that FETCH lasts exactly FETCH_WAIT cycles:
    // done is seen on the cycle the count reaches zero.
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(FETCH_WAIT - 1);

    pc_state_t        r_state;
    logic             r_branch_q;
    logic [CNT_W-1:0] r_retired;

    logic w_wc_load;
    logic w_wc_dec;
    logic w_wc_done;

    // Keep the counter primed outside FETCH so it is ready on entry.
    assign w_wc_load = (r_state != FETCH);
    assign w_wc_dec  = (r_state == FETCH);

    wait_counter #(
        .W (WAIT_W)
    ) u_wait (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_load     (w_wc_load),
        .i_load_val (WAIT_LOAD),
        .i_dec      (w_wc_dec),
        .o_done     (w_wc_done)
    );

    // Main sequencing FSM with branch capture and retired-instruction count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_branch_q <= 1'b0;
            r_retired  <= '0;
        end else begin
            case (r_state)
                IDLE, HALTED: begin
                    if (start) r_state <= LOAD_START;
                end
                LOAD_START: begin
                    r_retired <= '0;
                    r_state   <= FETCH;
                end
                FETCH: begin
                    if (w_wc_done) r_state <= DECODE;
                end
                DECODE: begin
                    r_state <= EXECUTE;
                end
                EXECUTE: begin
                    // branch_taken only matters on the exit cycle.
                    if (!exec_busy) begin
                        r_branch_q <= branch_taken;
                        r_state    <= PC_UPDATE;
                    end
                end
                PC_UPDATE: begin
                    r_retired <= r_retired + CNT_W'(1);
                    r_state   <= halt_req ? HALTED : FETCH;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of registered state; no input reaches them.
    assign load_pc = (r_state == LOAD_START) || (r_state == PC_UPDATE);
    assign sel_pc  = (r_state == LOAD_START)               ? PC_SEL_START :
                     ((r_state == PC_UPDATE) && r_branch_q) ? PC_SEL_DP    :
                                                              PC_SEL_INC;
    assign en_ir   = (r_state == FETCH) && w_wc_done;
    assign en_exec = (r_state == EXECUTE);
    assign running = (r_state != IDLE) && (r_state != HALTED);
    assign state_o = r_state;
    assign retired = r_retired;

endmodule
